// File: rtl/draw_rct_ctl.sv
// Rectangle sprite motion controller: follows the mouse until a click, then falls under
// gravity, bounces with energy loss on the floor and rests until the next click.
module draw_rct_ctl #(
  parameter logic [11:0] SCREEN_H     = 12'd600,
  parameter logic [11:0] RECT_H       = 12'd48,
  parameter logic [7:0]  G_ACCEL      = 8'd1,
  parameter logic [7:0]  V_MAX        = 8'd32,
  parameter int          BOUNCE_SHIFT = 1,
  parameter logic [7:0]  MIN_BOUNCE_V = 8'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        busy
);

  localparam logic [11:0] FLOOR = SCREEN_H - RECT_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    RISE = 2'd2,
    REST = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  vel_q, vel_d;
  logic [11:0] xpos_q, xpos_d;
  logic [11:0] ypos_q, ypos_d;
  logic        busy_q, busy_d;
  logic        pending_q, pending_d;
  logic        vblnk_d_q;
  logic        left_meta_q, left_s_q, left_s_d_q;

  logic        frame_tick;
  logic        left_rise;
  logic [8:0]  v_sum;
  logic [7:0]  v_fall;
  logic [12:0] y_sum;
  logic [7:0]  v_bounce;

  assign xpos = xpos_q;
  assign ypos = ypos_q;
  assign busy = busy_q;

  // Next-state and datapath for the once-per-frame motion update.
  always_comb begin
    state_d    = state_q;
    vel_d      = vel_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    frame_tick = vblnk & ~vblnk_d_q;
    left_rise  = left_s_q & ~left_s_d_q;
    // A click landing on the tick cycle must survive into the next frame.
    pending_d  = left_rise | (pending_q & ~frame_tick);
    v_sum      = {1'b0, vel_q} + {1'b0, G_ACCEL};
    if (v_sum > {1'b0, V_MAX}) begin
      v_fall = V_MAX;
    end else begin
      v_fall = v_sum[7:0];
    end
    y_sum    = {1'b0, ypos_q} + {5'd0, v_fall};
    v_bounce = v_fall >> BOUNCE_SHIFT;

    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (left_s_q) begin
            vel_d   = 8'd0;
            state_d = FALL;
          end else begin
            xpos_d = mouse_xpos;
            if (mouse_ypos > FLOOR) begin
              ypos_d = FLOOR;
            end else begin
              ypos_d = mouse_ypos;
            end
          end
        end
        FALL: begin
          if (y_sum < {1'b0, FLOOR}) begin
            ypos_d = y_sum[11:0];
            vel_d  = v_fall;
          end else begin
            ypos_d = FLOOR;
            if (v_bounce < MIN_BOUNCE_V) begin
              vel_d   = 8'd0;
              state_d = REST;
            end else begin
              vel_d   = v_bounce;
              state_d = RISE;
            end
          end
        end
        RISE: begin
          if ({4'd0, vel_q} > ypos_q) begin
            ypos_d  = 12'd0;
            vel_d   = 8'd0;
            state_d = FALL;
          end else begin
            ypos_d = ypos_q - {4'd0, vel_q};
            if (vel_q > G_ACCEL) begin
              vel_d = vel_q - G_ACCEL;
            end else begin
              vel_d   = 8'd0;
              state_d = FALL;
            end
          end
        end
        REST: begin
          ypos_d = FLOOR;
          if (pending_q) begin
            state_d = IDLE;
          end else begin
            state_d = REST;
          end
        end
        default: begin
          vel_d   = 8'd0;
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != IDLE);
  end

  // State, outputs, frame-edge detector and click synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vel_q       <= 8'd0;
      xpos_q      <= 12'd0;
      ypos_q      <= 12'd0;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      vblnk_d_q   <= 1'b1;
      left_meta_q <= 1'b0;
      left_s_q    <= 1'b0;
      left_s_d_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vel_q       <= vel_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      vblnk_d_q   <= vblnk;
      left_meta_q <= mouse_left;
      left_s_q    <= left_meta_q;
      left_s_d_q  <= left_s_q;
    end
  end

endmodule

// File: tb/tb_draw_rct_ctl.sv
// Self-checking bench for draw_rct_ctl: directed scenarios followed by randomized frames,
// all compared against a frame-level physics model of the sprite.
module tb_draw_rct_ctl;

  logic        clk;
  logic        rst;
  logic        vblnk;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        busy;

  int checks;
  int errors;

  // Model of the sprite in plain integers.
  localparam int FLOOR_Y = 552;
  int  m_x, m_y, m_vel;
  bit  m_moving;   // 0 = following the mouse
  bit  m_rising;
  bit  m_resting;
  bit  m_pending;
  bit  m_left;

  draw_rct_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_left (mouse_left),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .xpos       (xpos),
    .ypos       (ypos),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_vel = 0;
    m_moving = 0; m_rising = 0; m_resting = 0;
    m_pending = 0;
  endtask

  task automatic model_frame();
    int v;
    if (!m_moving) begin
      if (m_left) begin
        m_moving = 1; m_rising = 0; m_resting = 0; m_vel = 0;
      end else begin
        m_x = mouse_xpos;
        m_y = (mouse_ypos > FLOOR_Y) ? FLOOR_Y : int'(mouse_ypos);
      end
    end else if (m_resting) begin
      m_y = FLOOR_Y;
      if (m_pending) begin
        m_moving = 0; m_resting = 0;
      end
    end else if (m_rising) begin
      if (m_vel > m_y) begin
        m_y = 0; m_vel = 0; m_rising = 0;
      end else begin
        m_y = m_y - m_vel;
        m_vel = (m_vel > 1) ? m_vel - 1 : 0;
        if (m_vel == 0) m_rising = 0;
      end
    end else begin
      v = m_vel + 1;
      if (v > 32) v = 32;
      if (m_y + v >= FLOOR_Y) begin
        m_y = FLOOR_Y;
        if (v / 2 < 2) begin
          m_vel = 0; m_resting = 1;
        end else begin
          m_vel = v / 2; m_rising = 1;
        end
      end else begin
        m_y = m_y + v;
        m_vel = v;
      end
    end
    m_pending = 0;
  endtask

  task automatic set_left(input bit v);
    @(negedge clk);
    if (v && !m_left) m_pending = 1;
    mouse_left = v;
    m_left = v;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_left();
    set_left(1'b1);
    set_left(1'b0);
  endtask

  task automatic set_mouse(input int x, input int y);
    @(negedge clk);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
  endtask

  // One frame: blank low, rising edge, held high for a random number of lines.
  task automatic tick_frame(input string tag);
    @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
    vblnk = 1'b1;
    model_frame();
    repeat ($urandom_range(1, 8)) @(negedge clk);
    check_val({tag, "_x"}, int'(xpos), m_x);
    check_val({tag, "_y"}, int'(ypos), m_y);
    check_val({tag, "_busy"}, int'(busy), int'(m_moving));
  endtask

  initial begin
    int prev_y, max_step, n;
    checks = 0; errors = 0;
    rst = 1'b1; vblnk = 1'b0; mouse_left = 1'b0; m_left = 0;
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_x", int'(xpos), 0);
    check_val("rst_y", int'(ypos), 0);
    check_val("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1 / T2: follow and floor clamp
    set_mouse(100, 200);
    tick_frame("t1");
    check_val("t1_lit_y", int'(ypos), 200);
    set_mouse(10, 700);
    tick_frame("t2");
    check_val("t2_lit_y", int'(ypos), 552);

    // T3: click freezes position, then gravity sequence
    set_mouse(100, 200);
    tick_frame("t3_follow");
    set_left(1'b1);
    tick_frame("t3_arm");
    check_val("t3_held_y", int'(ypos), 200);
    set_left(1'b0);
    for (int i = 0; i < 4; i++) begin
      set_mouse($urandom_range(0, 1023), $urandom_range(0, 799));
      tick_frame("t3_fall");
    end
    check_val("t3_lit_y", int'(ypos), 210);
    check_val("t3_lit_x", int'(xpos), 100);
    n = 0;
    while (!m_resting && n < 300) begin
      tick_frame("t3_settle");
      n++;
    end
    check_val("t3_rest_reached", int'(m_resting), 1);

    // T5-style re-arm to follow, then T4: drop from the top
    pulse_left();
    tick_frame("t4_rearm");
    set_mouse(50, 0);
    tick_frame("t4_top");
    set_left(1'b1);
    tick_frame("t4_arm");
    set_left(1'b0);
    prev_y = int'(ypos); max_step = 0; n = 0;
    while (!m_resting && n < 300) begin
      tick_frame("t4_drop");
      if (!m_rising && int'(ypos) - prev_y > max_step) max_step = int'(ypos) - prev_y;
      prev_y = int'(ypos);
      n++;
    end
    check_val("t4_vmax", max_step, 32);
    check_val("t4_rest_y", int'(ypos), 552);
    check_val("t4_rest_busy", int'(busy), 1);
    tick_frame("t4_rest_hold");

    // T5: click while resting -> follow, next frame tracks mouse
    pulse_left();
    set_mouse(321, 123);
    tick_frame("t5_idle");
    check_val("t5_busy", int'(busy), 0);
    tick_frame("t5_track");
    check_val("t5_lit_y", int'(ypos), 123);
    check_val("t5_lit_x", int'(xpos), 321);

    // T6: reset mid-fall with vblnk high
    set_left(1'b1);
    tick_frame("t6_arm");
    set_left(1'b0);
    tick_frame("t6_fall");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t6_async_x", int'(xpos), 0);
    check_val("t6_async_y", int'(ypos), 0);
    check_val("t6_async_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (6) @(negedge clk);
    check_val("t6_notick_x", int'(xpos), 0);
    check_val("t6_notick_y", int'(ypos), 0);
    tick_frame("t6_resume");

    // Randomized frames
    for (int f = 0; f < 400; f++) begin
      int act;
      if (m_left) set_left(1'b0);
      act = $urandom_range(0, 19);
      if (act == 0) pulse_left();
      else if (act == 1) set_left(1'b1);
      set_mouse($urandom_range(0, 1023), $urandom_range(0, 799));
      tick_frame("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
